// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: address width, reset PC, fetch FSM states and
// opcode field extractors used by both the fetch stage and the execute core.
package chip8_pkg;
  localparam int          CHIP8_ADDR_W = 12;
  localparam logic [11:0] RESET_PC     = 12'h200;

  typedef enum logic [2:0] {
    IDLE, REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, VALID, DRAIN
  } fetch_state_e;

  function automatic logic [3:0]  op_x  (input logic [15:0] op); return op[11:8]; endfunction
  function automatic logic [3:0]  op_y  (input logic [15:0] op); return op[7:4];  endfunction
  function automatic logic [3:0]  op_n  (input logic [15:0] op); return op[3:0];  endfunction
  function automatic logic [7:0]  op_kk (input logic [15:0] op); return op[7:0];  endfunction
  function automatic logic [11:0] op_nnn(input logic [15:0] op); return op[11:0]; endfunction
endpackage

// File: rtl/chip8_fetch_if.sv
// Fetch-stage bus: request/flush from control, byte memory port, opcode handshake.
interface chip8_fetch_if
  import chip8_pkg::*;
#(parameter int ADDR_W = CHIP8_ADDR_W);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              flush;
  logic              busy;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_err;

  modport master (
    input  fetch_req, fetch_pc, flush, mem_rdata, mem_rvalid, instr_ready,
    output busy, mem_rd, mem_addr, instr, instr_valid, fetch_err
  );
  modport slave (
    output fetch_req, fetch_pc, flush, mem_rdata, mem_rvalid, instr_ready,
    input  busy, mem_rd, mem_addr, instr, instr_valid, fetch_err
  );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: two byte reads at pc and pc+1, assembled big-endian,
// presented over valid/ready; supports flush and a memory response timeout.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int ADDR_W   = CHIP8_ADDR_W,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  chip8_fetch_if.master bus
);
  localparam int            CW  = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_WAIT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     cnt_q;
  logic [15:0]       instr_q;
  logic              err_q;
  logic              waiting, expire, accept;

  assign waiting = (state_q == WAIT_HI) || (state_q == WAIT_LO) || (state_q == DRAIN);
  assign expire  = waiting && !bus.mem_rvalid && (cnt_q == LIM);
  assign accept  = (state_q == IDLE) && bus.fetch_req && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ_HI;
      REQ_HI:  state_d = bus.flush ? IDLE : WAIT_HI;
      WAIT_HI: begin
        // A response coinciding with flush is simply dropped; nothing left to drain.
        if (bus.mem_rvalid)  state_d = bus.flush ? IDLE : REQ_LO;
        else if (bus.flush)  state_d = DRAIN;
        else if (expire)     state_d = IDLE;
      end
      REQ_LO:  state_d = bus.flush ? IDLE : WAIT_LO;
      WAIT_LO: begin
        if (bus.mem_rvalid)  state_d = bus.flush ? IDLE : VALID;
        else if (bus.flush)  state_d = DRAIN;
        else if (expire)     state_d = IDLE;
      end
      VALID:   if (bus.instr_ready || bus.flush) state_d = IDLE;
      DRAIN:   if (bus.mem_rvalid || expire)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      if (accept) pc_q <= bus.fetch_pc;
      // Staying in a wait state implies no response this cycle; any entry restarts at 0.
      cnt_q <= (waiting && state_d == state_q) ? cnt_q + CW'(1) : '0;
      err_q <= expire && (state_d == IDLE);
      if (state_q == WAIT_HI && bus.mem_rvalid && !bus.flush) instr_q[15:8] <= bus.mem_rdata;
      if (state_q == WAIT_LO && bus.mem_rvalid && !bus.flush) instr_q[7:0]  <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    if ((state_q == REQ_HI || state_q == REQ_LO) && !bus.flush) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = (state_q == REQ_LO) ? pc_q + ADDR_W'(1) : pc_q;
    end
    bus.busy        = (state_q != IDLE);
    bus.instr_valid = (state_q == VALID);
    bus.instr       = instr_q;
    bus.fetch_err   = err_q;
  end
endmodule

// File: tb/tb_chip8_fetch.sv
// Directed + randomized bench for chip8_fetch with a latency-programmable byte memory.
module tb_chip8_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 clk = ~clk;

  chip8_fetch_if #(.ADDR_W(12)) bus ();
  chip8_fetch #(.ADDR_W(12), .MAX_WAIT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // memory model: answers each mem_rd after lat cycles unless muted
  logic [7:0]  mem [4096];
  int          lat  = 1;
  bit          mute = 1'b0;
  bit          pend;
  int          dcnt;
  logic [11:0] paddr;
  logic [11:0] addr_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      pend           <= 1'b0;
      bus.mem_rvalid <= 1'b0;
    end else begin
      bus.mem_rvalid <= 1'b0;
      if (pend && dcnt == 1) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= mem[paddr];
        pend           <= 1'b0;
      end else if (pend) dcnt <= dcnt - 1;
      if (bus.mem_rd) begin
        addr_q.push_back(bus.mem_addr);
        if (!mute) begin
          pend  <= 1'b1;
          dcnt  <= lat;
          paddr <= bus.mem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_fetch(input logic [11:0] pc);
    bus.fetch_pc  = pc;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.instr_valid && n < 100) begin tick(); n++; end
  endtask

  // Full fetch with hold cycles of backpressure; expected values from memory contents.
  task automatic run_fetch(input logic [11:0] pc, input int l, input int hold);
    logic [11:0] pc1;
    logic [15:0] exp;
    int n;
    lat = l;
    pc1 = pc + 12'd1;
    exp = {mem[pc], mem[pc1]};
    addr_q.delete();
    start_fetch(pc);
    chk("busy_after_req", bus.busy, 1);
    wait_valid(n);
    chk("valid_latency", n, 3 + 2*l);
    chk("instr", bus.instr, exp);
    chk("rd_count", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("addr_hi", addr_q[0], pc);
      chk("addr_lo", addr_q[1], pc1);
    end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.fetch_req = (i == 0);
      bus.fetch_pc  = ~pc;
      tick();
      bus.fetch_req = 1'b0;
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_instr", bus.instr, exp);
      chk("hold_busy", bus.busy, 1);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("done_valid", bus.instr_valid, 0);
    chk("done_busy", bus.busy, 0);
    chk("done_instr", bus.instr, exp);
    chk("no_extra_rd", addr_q.size(), 2);
  endtask

  initial begin
    int n, m;
    bit saw;
    bit found;
    logic [11:0] rpc;

    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.flush = 1'b0; bus.instr_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_err", bus.fetch_err, 0);
    rst_n = 1'b1;
    tick();

    // basic, wrap, backpressure
    mem[12'h200] = 8'h6A; mem[12'h201] = 8'h05;
    run_fetch(12'h200, 1, 0);
    mem[12'hFFF] = 8'h12; mem[12'h000] = 8'h34;
    run_fetch(12'hFFF, 1, 0);
    run_fetch(12'h2A0, 1, 10);

    for (int k = 0; k < 10; k++) begin
      rpc = 12'($urandom_range(0, 4095));
      mem[rpc] = 8'($urandom);
      run_fetch(rpc, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    // flush while the low-byte read is outstanding
    lat = 4;
    start_fetch(12'h250);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_rd && bus.mem_addr == 12'h251) found = 1'b1;
      else tick();
    end
    chk("reach_req_lo", found, 1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("drain_busy", bus.busy, 1);
    m = 0; saw = 1'b0;
    while (bus.busy && m < 20) begin tick(); m++; saw |= bus.instr_valid; end
    chk("drain_len", m, 3);
    chk("drain_no_valid", saw, 0);
    mem[12'h300] = 8'hA3; mem[12'h301] = 8'hC7;
    run_fetch(12'h300, 1, 0);

    // flush while holding a valid opcode
    lat = 2;
    start_fetch(12'h3AB);
    wait_valid(n);
    chk("vflush_latency", n, 7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("vflush_valid", bus.instr_valid, 0);
    chk("vflush_busy", bus.busy, 0);

    // flush in REQ_HI suppresses the strobe
    addr_q.delete();
    start_fetch(12'h111);
    bus.flush = 1'b1;
    #1 chk("rflush_no_rd", bus.mem_rd, 0);
    tick();
    bus.flush = 1'b0;
    chk("rflush_busy", bus.busy, 0);
    repeat (3) tick();
    chk("rflush_rd_count", addr_q.size(), 0);

    // flush and fetch_req together in IDLE
    bus.flush = 1'b1; bus.fetch_req = 1'b1; bus.fetch_pc = 12'h222;
    tick();
    bus.flush = 1'b0; bus.fetch_req = 1'b0;
    tick();
    chk("iflush_busy", bus.busy, 0);
    chk("iflush_rd_count", addr_q.size(), 0);

    // timeout: no response ever
    mute = 1'b1;
    start_fetch(12'h456);
    n = 1;
    while (!bus.fetch_err && n < 40) begin tick(); n++; end
    chk("timeout_cycle", n, 17);
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_valid", bus.instr_valid, 0);
    tick();
    chk("timeout_pulse", bus.fetch_err, 0);
    mute = 1'b0;

    // async reset while waiting for the high byte
    lat = 4;
    start_fetch(12'h123);
    tick();
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_mem_rd", bus.mem_rd, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_instr", bus.instr, 16'h0000);
    chk("arst_valid", bus.instr_valid, 0);
    chk("arst_err", bus.fetch_err, 0);
    tick();
    rst_n = 1'b1;
    addr_q.delete();
    repeat (3) tick();
    chk("arst_no_rd", addr_q.size(), 0);
    chk("arst_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chip8_fetch.md
Name: chip8_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the CHIP-8 execute core.
- On a fetch request it reads two consecutive bytes from the 4 KiB byte-wide system memory at the supplied program counter. It assembles them big-endian into a 16-bit opcode and presents it to the execute core over a valid/ready handshake.
- Supports flush for jumps, calls, returns and skips.

Parameters:
- ADDR_W, 12, memory address width in bits; address arithmetic wraps modulo 2^ADDR_W.
- MAX_WAIT, 15, maximum cycles to wait for mem_rvalid before raising fetch_err.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  one-cycle pulse: start a fetch at fetch_pc.
- fetch_pc  in  ADDR_W  address of the opcode high byte; sampled when fetch_req is accepted.
- flush  in  1  abort any fetch in progress and drop any held opcode.
- busy  out  1  high from request acceptance until the opcode handshake completes or a flush occurs.
- mem_rd  out  1  one-cycle read strobe to memory.
- mem_addr  out  ADDR_W  read address; valid while mem_rd is high.
- mem_rdata  in  8  read data; valid when mem_rvalid is high.
- mem_rvalid  in  1  read response strobe, at least 1 cycle after mem_rd; at most one read is outstanding.
- instr  out  16  assembled opcode, {high byte, low byte}.
- instr_valid  out  1  instr is valid; held high until instr_ready.
- instr_ready  in  1  execute core accepts instr.
- fetch_err  out  1  one-cycle pulse when a memory response has timed out.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state = IDLE
  - mem_rd = 0, mem_addr = 0
  - instr = 16'h0000, instr_valid = 0
  - busy = 0, fetch_err = 0
  - internal PC latch = 0, wait counter = 0
- States: IDLE, REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, VALID, DRAIN.
- IDLE:
  - fetch_req=1 → latch fetch_pc, go to REQ_HI, busy=1 from the next cycle.
- REQ_HI:
  - mem_rd=1, mem_addr=pc_latch for exactly this cycle → WAIT_HI.
- WAIT_HI:
  - On mem_rvalid, capture mem_rdata into instr[15:8] → REQ_LO.
- REQ_LO:
  - mem_rd=1, mem_addr=(pc_latch+1) mod 2^ADDR_W; pc 12'hFFF reads its low byte from 12'h000 → WAIT_LO.
- WAIT_LO:
  - On mem_rvalid, capture into instr[7:0] → VALID.
- VALID:
  - instr_valid=1, instr stable.
  - instr_ready=1 → IDLE, with instr_valid=0 and busy=0 the next cycle. instr retains its last value.
- Latency: with 1-cycle memory, fetch_req at cycle 0 gives instr_valid at cycle 5.
- Minimum request-to-request spacing is 6 cycles when instr_ready is tied high.
- fetch_req while not in IDLE: ignored, no queuing.
- Odd fetch_pc: legal, fetched as given; no alignment fault.
- flush (highest priority):
  - From REQ_HI, REQ_LO or VALID → IDLE next cycle; instr_valid drops next cycle. In REQ_* no mem_rd is issued in the flush cycle.
  - From WAIT_HI or WAIT_LO → DRAIN; the outstanding response is discarded.
  - In DRAIN: mem_rvalid → IDLE. busy=1 throughout DRAIN; fetch_req in DRAIN is ignored.
  - flush in IDLE or DRAIN: no effect.
  - flush and fetch_req in the same cycle while IDLE: flush wins and the request is ignored.
  - flush and instr_ready in the same cycle in VALID: the handshake completes and the state goes to IDLE; the core owns the consequence.
- Timeout:
  - Wait counter resets on entry to any WAIT_*/DRAIN state and increments each cycle without mem_rvalid.
  - At MAX_WAIT: pulse fetch_err for 1 cycle, go to IDLE, busy=0, instr_valid stays 0.
- mem_rvalid outside WAIT_*/DRAIN: ignored.
- rst_n asserted mid-fetch: immediate return to reset values; no mem_rd glitch after release.

Decomposition:
- Shared package chip8_pkg holds:
  - ADDR_W default and RESET_PC = 12'h200
  - fetch state enum type
  - opcode field helpers (nibble positions x, y, n, kk, nnn) for reuse by the execute core.
- No sub-module is needed; the single FSM plus PC and wait counters is natural at ~150-200 lines.

Test Plan:
- Basic fetch: memory 0x200=8'h6A, 0x201=8'h05, 1-cycle latency, fetch_req with fetch_pc=12'h200 → mem_addr 12'h200 then 12'h201, instr=16'h6A05, instr_valid at cycle 5.
- Wrap: fetch_pc=12'hFFF, mem[FFF]=8'h12, mem[000]=8'h34 → second mem_addr=12'h000, instr=16'h1234.
- Backpressure: instr_ready held low 10 cycles → instr_valid and instr stable all 10 cycles, second fetch_req ignored, busy=1; instr_ready=1 → IDLE next cycle.
- Flush during WAIT_LO with 4-cycle memory latency → DRAIN, late response discarded, instr_valid never rises. The next fetch_pc=12'h300 returns mem[300..301] correctly.
- Timeout: mem_rvalid never asserted → fetch_err single pulse 15 cycles after WAIT_HI entry, busy=0, instr_valid=0.
- Async reset asserted in WAIT_HI → all outputs at reset values immediately, no spurious mem_rd for 3 cycles after release.
